mac_step_sequencer: RTL and testbench
=====================================

// Module: mac_step_sequencer
// PURPOSE
//  Control FSM for the serial shift-add MAC. Accepts a start handshake, loads
//  operands, issues N_STEPS shift/add cycles from an internal step counter,
//  then holds a result handshake until the consumer takes it. Sits between
//  the MAC top-level request interface and the operand/accumulator registers.
// PARAMETERS
//  N_STEPS  8  shift/add iterations per operation (multiplier width); 2..2**CNT_W
//  CNT_W    3  step counter width; N_STEPS <= 2**CNT_W
// PORTS
//  clk_i           in  1      clock; all state changes on rising edge
//  nreset_i        in  1      asynchronous, active-low reset
//  start_valid_i   in  1      operand pair presented
//  start_ready_o   out 1      sequencer idle, can accept
//  acc_mode_i      in  1      1 = add onto accumulator; 0 = clear first; sampled at accept
//  abort_i         in  1      synchronous abort, returns to IDLE
//  mult_bit_i      in  1      current LSB of datapath multiplier shift register
//  load_o          out 1      load operand registers (1-cycle pulse)
//  acc_clear_o     out 1      clear accumulator (1-cycle pulse, with load_o)
//  shift_en_o      out 1      shift multiplier right / multiplicand left
//  add_en_o        out 1      add multiplicand into accumulator this cycle
//  step_o          out CNT_W  current iteration index
//  busy_o          out 1      operation in flight (LOAD, RUN, DONE)
//  result_valid_o  out 1      accumulator holds final result
//  result_ready_i  in  1      consumer takes result
// BEHAVIOUR
//  - Reset (async, nreset_i=0): state IDLE, step=0; start_ready_o=1, all
//    other outputs 0; applies immediately, also mid-operation.
//  - States IDLE, LOAD, RUN, DONE. Outputs Moore-decoded from state, except
//    add_en_o = (state==RUN) & mult_bit_i.
//  - IDLE: start_ready_o=1. start_valid_i & start_ready_o at edge -> LOAD;
//    acc_mode_i captured into register at that edge.
//  - LOAD (1 cycle): load_o=1, acc_clear_o=~captured acc_mode, step=0 -> RUN.
//  - RUN: shift_en_o=1, step_o = 0..N_STEPS-1, +1 per cycle. At
//    step==N_STEPS-1 -> DONE, step cleared to 0 (no wrap past N_STEPS-1).
//  - DONE: result_valid_o=1, held stable until result_valid_o & result_ready_i
//    at an edge -> IDLE. No new accept in the same cycle (1 idle cycle min).
//  - Latency: accept at edge 0; LOAD cycle 1; RUN cycles 2..N_STEPS+1;
//    result_valid_o high from cycle N_STEPS+2 (10 for default).
//  - start_valid_i ignored outside IDLE; start_ready_o=0 there.
//  - abort_i=1 at an edge: -> IDLE, step=0, from any state; priority over
//    start and over result handshake. In IDLE, abort blocks the accept.
//  - busy_o = (state != IDLE). Exactly one of start_ready_o/busy_o is high.
//  - mult_bit_i affects only add_en_o; never state or step.
// STRUCTURE
//  - Shared include mac_defines.vh: state encoding localparams (IDLE=2'd0,
//    LOAD=2'd1, RUN=2'd2, DONE=2'd3), default N_STEPS/CNT_W.
//  - Sub-module mac_step_counter: CNT_W-bit rising-edge counter, async
//    active-low reset, sync clear, enable; terminal flag at N_STEPS-1.
//  - Top: FSM register, acc_mode capture register, output decode.
// TESTING
//  1 Reset mid-RUN (step=4): drop nreset_i -> same cycle step_o=0,
//    shift_en_o=0, start_ready_o=1; after release accepts new start.
//  2 Basic op, acc_mode=0, mult bits 1,0,1,1,0,0,0,1: load_o/acc_clear_o at
//    cycle 1; shift_en_o cycles 2-9; add_en_o high at steps 0,2,3,7;
//    result_valid_o at cycle 10.
//  3 acc_mode=1: load_o=1 with acc_clear_o=0; timing otherwise as test 2.
//  4 Backpressure: result_ready_i=0 for 5 cycles in DONE -> result_valid_o
//    stays 1, step_o=0, start_valid_i=1 not accepted; ready=1 -> IDLE next.
//  5 Abort at RUN step 3 with start_valid_i=1 -> IDLE next cycle, no
//    result_valid_o; accept occurs the following edge.
//  6 Params N_STEPS=5, CNT_W=3: step_o 0..4 then DONE at cycle 7; step_o
//    never reaches 5.

Source files
------------

// File: rtl/mac_step_sequencer_pkg.sv
// Shared types and defaults for the serial shift-add MAC step sequencer.
package mac_step_sequencer_pkg;

    // Sequencer states; the numeric codes are visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Default multiplier width and matching step counter width.
    localparam int DEF_N_STEPS = 8;
    localparam int DEF_CNT_W   = 3;

    // Last step index for a given operation length, sized to the counter.
    function automatic int last_step(input int n_steps);
        return n_steps - 1;
    endfunction

endpackage

// File: rtl/mac_step_sequencer_counter.sv
// Step counter for the MAC sequencer: counts 0..N_STEPS-1 while enabled,
// flags the last step and returns to 0 after it instead of wrapping further.
module mac_step_sequencer_counter
    import mac_step_sequencer_pkg::*;
#(
    parameter int N_STEPS = DEF_N_STEPS,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(last_step(N_STEPS));

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    // Terminal flag is purely the count value; the owner qualifies it with state.
    always_comb begin
        w_term = (r_cnt == LP_LAST);
    end

    // Count register: clear wins over enable; terminal count folds back to 0.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            if (w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cnt_o  = r_cnt;
    assign term_o = w_term;

endmodule

// File: rtl/mac_step_sequencer.sv
// Control FSM for the serial shift-add MAC: start handshake, one load cycle,
// N_STEPS shift/add cycles, then a held result handshake.
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both high; a valid, once raised by the sequencer, stays high until taken.
module mac_step_sequencer
    import mac_step_sequencer_pkg::*;
#(
    parameter int N_STEPS = DEF_N_STEPS,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             acc_mode_i,
    input  logic             abort_i,
    input  logic             mult_bit_i,
    output logic             load_o,
    output logic             acc_clear_o,
    output logic             shift_en_o,
    output logic             add_en_o,
    output logic [CNT_W-1:0] step_o,
    output logic             busy_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [1:0]       dbg_state_o
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic             r_acc_mode;
    logic             w_accept;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_term;
    logic [CNT_W-1:0] w_step;

    // Accept qualifier: idle, offered, and not being aborted this edge.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && start_valid_i && !abort_i;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_valid_i)  w_next = ST_LOAD;
            ST_LOAD:                     w_next = ST_RUN;
            ST_RUN:  if (w_term)         w_next = ST_DONE;
            ST_DONE: if (result_ready_i) w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
        endcase
        if (abort_i) begin
            w_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Accumulate-mode capture at the accepting edge only.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_acc_mode <= 1'b0;
        end else if (w_accept) begin
            r_acc_mode <= acc_mode_i;
        end
    end

    // Counter runs only in RUN and is held at 0 everywhere else or on abort.
    always_comb begin
        w_cnt_en  = (r_state == ST_RUN);
        w_cnt_clr = (r_state != ST_RUN) || abort_i;
    end

    mac_step_sequencer_counter #(
        .N_STEPS (N_STEPS),
        .CNT_W   (CNT_W)
    ) u_counter (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .clr_i    (w_cnt_clr),
        .en_i     (w_cnt_en),
        .cnt_o    (w_step),
        .term_o   (w_term)
    );

    // Output decode: Moore from state, except add_en which follows mult_bit in RUN.
    always_comb begin
        start_ready_o  = 1'b0;
        load_o         = 1'b0;
        acc_clear_o    = 1'b0;
        shift_en_o     = 1'b0;
        add_en_o       = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                start_ready_o = 1'b1;
                busy_o        = 1'b0;
            end
            ST_LOAD: begin
                load_o      = 1'b1;
                acc_clear_o = !r_acc_mode;
            end
            ST_RUN: begin
                shift_en_o = 1'b1;
                add_en_o   = mult_bit_i;
            end
            ST_DONE: begin
                result_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign step_o      = w_step;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mac_step_sequencer.sv
// Bench for mac_step_sequencer: directed scenarios plus randomized operations,
// checked every cycle against a timeline model keyed on cycles since accept.
module tb_mac_step_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    // ---------------- DUT A (default 8 steps) ----------------
    logic       a_sv, a_am, a_ab, a_rr;
    logic       a_sr, a_ld, a_ac, a_sh, a_ad, a_busy, a_rv;
    logic [2:0] a_step;
    logic [1:0] a_st;
    logic       mb;

    mac_step_sequencer u_dut_a (
        .clk_i          (clk),
        .nreset_i       (nreset),
        .start_valid_i  (a_sv),
        .start_ready_o  (a_sr),
        .acc_mode_i     (a_am),
        .abort_i        (a_ab),
        .mult_bit_i     (mb),
        .load_o         (a_ld),
        .acc_clear_o    (a_ac),
        .shift_en_o     (a_sh),
        .add_en_o       (a_ad),
        .step_o         (a_step),
        .busy_o         (a_busy),
        .result_valid_o (a_rv),
        .result_ready_i (a_rr),
        .dbg_state_o    (a_st)
    );

    // ---------------- DUT B (5 steps) ----------------
    logic       b_sv, b_am, b_ab, b_rr;
    logic       b_sr, b_ld, b_ac, b_sh, b_ad, b_busy, b_rv;
    logic [2:0] b_step;
    logic [1:0] b_st;

    mac_step_sequencer #(.N_STEPS(5), .CNT_W(3)) u_dut_b (
        .clk_i          (clk),
        .nreset_i       (nreset),
        .start_valid_i  (b_sv),
        .start_ready_o  (b_sr),
        .acc_mode_i     (b_am),
        .abort_i        (b_ab),
        .mult_bit_i     (mb),
        .load_o         (b_ld),
        .acc_clear_o    (b_ac),
        .shift_en_o     (b_sh),
        .add_en_o       (b_ad),
        .step_o         (b_step),
        .busy_o         (b_busy),
        .result_valid_o (b_rv),
        .result_ready_i (b_rr),
        .dbg_state_o    (b_st)
    );

    logic [12:0] a_obs, b_obs;
    assign a_obs = {a_sr, a_busy, a_ld, a_ac, a_sh, a_ad, a_rv, a_step, a_st};
    assign b_obs = {b_sr, b_busy, b_ld, b_ac, b_sh, b_ad, b_rv, b_step, b_st};

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard of expected step indices for the RUN phase of an operation.
    logic [2:0] exp_q[$];

    // ---------------- reference model ----------------
    // k = cycles since the accepting edge (0 = idle). k=1 load, k=2..n+1 run
    // with step k-2, k>=n+2 result held. State code follows the documented
    // encoding IDLE=0, LOAD=1, RUN=2, DONE=3.
    function automatic logic [12:0] exp_vec(input int k, input int n, input bit am, input bit m);
        bit         idle, ld, run, dn;
        logic [2:0] st;
        logic [1:0] code;
        idle = (k == 0);
        ld   = (k == 1);
        run  = (k >= 2) && (k <= n + 1);
        dn   = (k >= n + 2);
        st   = run ? 3'(k - 2) : 3'd0;
        code = idle ? 2'd0 : ld ? 2'd1 : run ? 2'd2 : 2'd3;
        return {idle, !idle, ld, ld & !am, run, run & m, dn, st, code};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit use_b, input bit sv, input bit am, input bit rr, input bit ab);
        if (use_b) begin
            b_sv = sv; b_am = am; b_rr = rr; b_ab = ab;
        end else begin
            a_sv = sv; a_am = am; a_rr = rr; a_ab = ab;
        end
    endtask

    // Compare all outputs of one DUT against the model, no clock advance.
    task automatic chk(input string tag, input bit use_b, input int k, input int n,
                       input bit am, input bit m);
        logic [12:0] obs, expv;
        mb = m;
        #1;
        obs  = use_b ? b_obs : a_obs;
        expv = exp_vec(k, n, am, m);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, expv);
        end
    endtask

    // Check, then advance to 1 time unit past the next rising edge.
    task automatic cyc(input string tag, input bit use_b, input int k, input int n,
                       input bit am, input bit m);
        chk(tag, use_b, k, n, am, m);
        @(posedge clk);
        #1;
    endtask

    // Offer a start in idle; returns positioned in the load cycle.
    task automatic start_op(input string tag, input bit use_b, input int n, input bit am);
        drive(use_b, 1'b1, am, 1'b0, 1'b0);
        cyc({tag, "_idle"}, use_b, 0, n, am, 1'($urandom));
        drive(use_b, 1'b0, 1'($urandom), 1'b0, 1'b0);
    endtask

    // Walk cycles k0..k1 of an operation, feeding multiplier bits in RUN.
    task automatic run_cycles(input string tag, input bit use_b, input int n, input bit am,
                              input logic [7:0] bits, input int k0, input int k1);
        bit m;
        for (int k = k0; k <= k1; k++) begin
            if (k >= 2 && k <= n + 1) begin
                m = bits[k-2];
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $error("FAIL %s_sb observed=empty expected=step", tag);
                end else begin
                    n_tests++;
                    assert ((use_b ? b_step : a_step) === exp_q[0]) else begin
                        n_fail++;
                        $error("FAIL %s_sb observed=%0d expected=%0d", tag,
                               (use_b ? b_step : a_step), exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end else begin
                m = 1'($urandom);
            end
            cyc(tag, use_b, k, n, am, m);
        end
    endtask

    // Hold the result for 'delay' cycles with a competing start, then take it.
    task automatic finish_op(input string tag, input bit use_b, input int n, input bit am,
                             input int delay);
        for (int d = 0; d < delay; d++) begin
            drive(use_b, 1'b1, 1'($urandom), 1'b0, 1'b0);
            cyc({tag, "_hold"}, use_b, n + 2, n, am, 1'($urandom));
        end
        drive(use_b, 1'b1, 1'($urandom), 1'b1, 1'b0);
        cyc({tag, "_take"}, use_b, n + 2, n, am, 1'($urandom));
        drive(use_b, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_after"}, use_b, 0, n, am, 1'($urandom));
    endtask

    task automatic load_sb(input int n);
        exp_q.delete();
        for (int s = 0; s < n; s++) exp_q.push_back(3'(s));
    endtask

    task automatic full_op(input string tag, input bit use_b, input int n, input bit am,
                           input logic [7:0] bits, input int delay);
        load_sb(n);
        start_op(tag, use_b, n, am);
        run_cycles(tag, use_b, n, am, bits, 1, n + 1);
        finish_op(tag, use_b, n, am, delay);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] bits;
        bit         am;

        nreset = 1'b0;
        mb     = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_a", 1'b0, 0, 8, 1'b0, 1'b1);
        chk("reset_b", 1'b1, 0, 5, 1'b0, 1'b1);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Test 2: basic op, clear mode, bits 1,0,1,1,0,0,0,1 (LSB first)
        full_op("basic", 1'b0, 8, 1'b0, 8'b1000_1101, 0);

        // Test 3: accumulate mode
        full_op("accum", 1'b0, 8, 1'b1, 8'b0110_0101, 0);

        // Test 4: backpressure for 5 cycles with a start pending
        full_op("bp", 1'b0, 8, 1'b0, 8'b1111_0000, 5);

        // Test 1: reset while in RUN at step 4
        load_sb(8);
        start_op("rst", 1'b0, 8, 1'b0);
        run_cycles("rst", 1'b0, 8, 1'b0, 8'b1111_1111, 1, 5);
        chk("rst_step4", 1'b0, 6, 8, 1'b0, 1'b1);
        nreset = 1'b0;
        chk("rst_async", 1'b0, 0, 8, 1'b0, 1'b1);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        full_op("rst_after", 1'b0, 8, 1'b1, 8'b0000_0011, 1);

        // Test 5: abort at RUN step 3 with a start pending
        load_sb(8);
        start_op("abort", 1'b0, 8, 1'b0);
        run_cycles("abort", 1'b0, 8, 1'b0, 8'b0000_1000, 1, 4);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc("abort_step3", 1'b0, 5, 8, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("abort_idle", 1'b0, 0, 8, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_sb(8);
        run_cycles("abort_reacc", 1'b0, 8, 1'b1, 8'b1010_1010, 1, 9);
        finish_op("abort_reacc", 1'b0, 8, 1'b1, 0);

        // Abort in idle blocks the accept
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("abort_blk", 1'b0, 0, 8, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("abort_blk_idle", 1'b0, 0, 8, 1'b0, 1'b0);

        // Test 6: five-step instance
        full_op("n5", 1'b1, 5, 1'b0, 8'b0001_0110, 2);

        // Randomized operations on both instances
        for (int r = 0; r < 12; r++) begin
            bits = 8'($urandom);
            am   = 1'($urandom);
            full_op("rand_a", 1'b0, 8, am, bits, $urandom_range(0, 3));
            bits = 8'($urandom);
            am   = 1'($urandom);
            full_op("rand_b", 1'b1, 5, am, bits, $urandom_range(0, 3));
        end

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
